sar_search: RTL
===============

Name: sar_search

Overview:
- Successive-approximation search controller for the comparator family: the drive-side counterpart of a magnitude comparator.
- Generates a trial word, consumes the external comparator's greater/less verdict, and converges one bit per clock on an unknown target value.
- Sits between a start/done requester and any combinational comparator whose one input is the unknown target and whose other input is trial.

Parameters:
WIDTH, 8, bit width of trial/result; number of search steps (>=2)

Ports:
clk     input   1      rising-edge clock
rst_n   input   1      asynchronous active-low reset
start   input   1      request a search; sampled only in IDLE
greater input   1      comparator verdict: target > trial (combinational from current trial)
less    input   1      comparator verdict: target < trial
trial   output  WIDTH  registered trial word driven to comparator
busy    output  1      high while a search is in progress
done    output  1      one-cycle pulse: result valid
result  output  WIDTH  registered final value, held until next done
err     output  1      valid with done: greater and less were both seen high during this search

Behaviour:
- Reset: async on rst_n low. Clears trial, result, busy, done, err, bit index, sticky error; state=IDLE. Reset mid-search aborts with no done.
- States: IDLE, SEARCH. Register idx spans 0..WIDTH-1.
- IDLE:
  - done=0.
  - Edge with start=1 loads trial to 1<<(WIDTH-1), idx to WIDTH-1, clears sticky error, and moves to SEARCH. busy goes 1 from the next cycle.
  - start=0 holds trial and result.
- SEARCH, each edge (bit = idx):
  - If less=1, clear trial[idx]; otherwise keep it. greater only breaks ties against illegal inputs.
  - If greater=1 and less=1 together, set the sticky error and clear the bit (less has priority).
  - If idx>0, also set trial[idx-1] and decrement idx.
  - If idx==0, load result from the final trial and err from the sticky error (including this cycle). done pulses high for exactly the next cycle, busy drops, state returns to IDLE, and trial holds the final value.
- Latency: start accepted at edge k leads to done high in the cycle after edge k+WIDTH. Fixed WIDTH cycles without the optional feature.
- start while busy is ignored, with no queuing. start high in the done cycle (state IDLE) is accepted: back-to-back searches give one idle/done cycle between them.
- Comparator inputs are sampled only in SEARCH and ignored in IDLE.
- Arithmetic: pure bit set/clear; no wrap possible.
  - Target 0 converges to 0: all trials less.
  - Target 2^WIDTH-1 converges to all ones: no trial less.

Optional Feature:
SAR_SEARCH_EARLY_EXIT_EN
- Defined: in SEARCH, a cycle with greater=0 and less=0 (equal) terminates immediately. result loads the current trial, err loads the sticky error, done pulses next cycle, and state returns to IDLE. Latency varies from 1 to WIDTH cycles.
- Undefined: equality is treated as "keep bit" and the search always runs WIDTH cycles. The final result is identical either way.

Test Plan (WIDTH=8; bench comparator models target vs trial combinationally):
1. Assert rst_n=0, release, idle 3 cycles -> trial=0, result=0, busy=0, done=0, err=0 throughout.
2. target=0xA5, pulse start -> trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5 on successive cycles; done 8 cycles after start edge; result=0xA5, err=0.
3. target=0x00, then target=0xFF, back-to-back starts -> results 0x00 and 0xFF, each in 8 cycles, one done pulse each. With SAR_SEARCH_EARLY_EXIT_EN and target=0x80 -> done after 1 cycle, result=0x80.
4. target=0x3C; re-assert start at cycle 3 of the search; then on a second search drop rst_n at cycle 4 -> first search unaffected (result=0x3C, single done); second aborted with all outputs 0 and no done.
5. Force greater=less=1 on the first SEARCH cycle, target=0x7F otherwise -> bit7 cleared, result=0x7F, err=1 with done; next clean search gives err=0.

Source files
------------

// File: rtl/sar_search_if.sv
// Request/comparator bundle for the successive-approximation search controller.
interface sar_search_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             greater;
  logic             less;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  // Requester plus external comparator side.
  modport master (
    output start, greater, less,
    input  trial, busy, done, result, err
  );

  modport slave (
    input  start, greater, less,
    output trial, busy, done, result, err
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search: drives a trial word into an external comparator and converges
// one bit per clock. Optional early exit on equality: SAR_SEARCH_EARLY_EXIT_EN.
module sar_search #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sar_search_if.slave  bus
);
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StSearch} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             sticky_q, sticky_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      sticky_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    sticky_d = sticky_q;
    err_d    = err_q;
    done_d   = 1'b0;
    finish   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          trial_d            = '0;
          trial_d[WIDTH-1]   = 1'b1;
          idx_d              = IdxW'(WIDTH - 1);
          sticky_d           = 1'b0;
          state_d            = StSearch;
        end
      end

      StSearch: begin
        // less wins a contradictory verdict; the contradiction is remembered for err.
        if (bus.less) begin
          trial_d[idx_q] = 1'b0;
        end
        if (bus.greater && bus.less) begin
          sticky_d = 1'b1;
        end

`ifdef SAR_SEARCH_EARLY_EXIT_EN
        finish = (idx_q == '0) || (!bus.greater && !bus.less);
`else
        finish = (idx_q == '0);
`endif

        if (finish) begin
          result_d = trial_d;
          err_d    = sticky_d;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          trial_d[idx_q - IdxW'(1)] = 1'b1;
          idx_d                     = idx_q - IdxW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.trial  = trial_q;
  assign bus.result = result_q;
  assign bus.busy   = (state_q == StSearch);
  assign bus.done   = done_q;
  assign bus.err    = err_q;
endmodule
